sram_responder: RTL and testbench

- Synthesizable device-side model of the 256K x 16 asynchronous SRAM that sits on the other end of the SRAM controller's DE2-style pin interface.
- It decodes the active-low chip, output, write and byte enables, stores byte-lane writes, and returns read data on SRAM_DQ after a configurable cycle latency.
- Used as the memory behind the MEM stage in system simulation and FPGA loopback builds, so the controller's wait/ready handling is exercised without the physical chip.

---
 rtl/sram_resp_pkg.sv | 24 ++
 rtl/sram_resp_array.sv | 39 +++
 rtl/sram_responder.sv | 140 ++++++++++++++
 tb/tb_sram_responder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SRAM device-side responder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sram_resp_pkg;

  // Byte lane width; the data bus is always two of these.
  localparam int BYTE_W = 8;

  // Width of the read-latency down counter (covers RD_LAT-1 up to 6).
  localparam int LAT_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WRITE    = 2'd1,
    RD_WAIT  = 2'd2,
    RD_DRIVE = 2'd3
  } state_t;

  // Counter preload for a given read latency: the load edge is when it hits 0.
  function automatic logic [LAT_W-1:0] lat_load(input int rd_lat);
    return LAT_W'(rd_lat - 1);
  endfunction

endpackage

// File: rtl/sram_resp_array.sv
// Two byte-wide storage arrays with per-lane write enables and a registered read port.
// Latency: write lands at the enabled edge; read data registered one edge after rd_en.
// Backpressure: none; every enabled access completes on its edge.
module sram_resp_array
  import sram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [2*BYTE_W-1:0]   wr_dat,
  input  logic [1:0]            wr_be,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [2*BYTE_W-1:0]   rd_dat
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [BYTE_W-1:0] mem_lo [DEPTH];
  logic [BYTE_W-1:0] mem_hi [DEPTH];

  // Lane writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_be[0]) mem_lo[wr_idx] <= wr_dat[BYTE_W-1:0];
    if (wr_be[1]) mem_hi[wr_idx] <= wr_dat[2*BYTE_W-1:BYTE_W];
  end

  // Output data register, cleared by reset, loaded only on the read-load edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= {mem_hi[rd_idx], mem_lo[rd_idx]};
    end
  end

endmodule

// File: rtl/sram_responder.sv
// Device-side model of a 256K x 16 async SRAM behind a DE2-style pin interface.
// Latency: read data driven RD_LAT clocks after request/address change (RD_LAT 1..7); writes land per edge.
// Backpressure: none; the controller paces via enables. Optional SRAM_RESP_STATS_EN adds rd_cnt/wr_cnt.
module sram_responder
  import sram_resp_pkg::*;
#(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 16,
  parameter int RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_UB_EN,
  input  logic              SRAM_LB_EN,
  input  logic              SRAM_WE_EN,
  input  logic              SRAM_CE_EN,
  input  logic              SRAM_OE_EN,
  output logic              rd_valid,
  output logic              proto_err
`ifdef SRAM_RESP_STATS_EN
  ,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
`endif
);

  state_t                  state;
  logic [LAT_W-1:0]        cnt;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       rd_dat;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    wr;
  logic                    rd;
  logic                    viol;
  logic                    addr_chg;
  logic                    wr_edge;
  logic [1:0]              wr_be;
  logic                    rd_load;
  logic                    drive;

  // Request decode; write wins when WE and OE are both low.
  assign wr       = !SRAM_CE_EN && !SRAM_WE_EN;
  assign rd       = !SRAM_CE_EN &&  SRAM_WE_EN && !SRAM_OE_EN;
  assign viol     = !SRAM_CE_EN && !SRAM_WE_EN && !SRAM_OE_EN;
  assign idx      = SRAM_ADDR[DEPTH_LOG2-1:0];
  assign addr_chg = (SRAM_ADDR != addr_q);
  assign wr_edge  = (state == WRITE) && wr;
  assign wr_be    = {2{wr_edge}} & {!SRAM_UB_EN, !SRAM_LB_EN};
  assign rd_load  = (state == RD_WAIT) && rd && (cnt == '0);

  // Drive gate is combinational on the pins so release never lags the controller.
  assign drive = !SRAM_CE_EN && !SRAM_OE_EN && SRAM_WE_EN && (state == RD_DRIVE);
  assign SRAM_DQ[DATA_W-1:BYTE_W] = (drive && !SRAM_UB_EN) ? rd_dat[DATA_W-1:BYTE_W] : 'z;
  assign SRAM_DQ[BYTE_W-1:0]      = (drive && !SRAM_LB_EN) ? rd_dat[BYTE_W-1:0]      : 'z;

  sram_resp_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .wr_idx (idx),
    .wr_dat (SRAM_DQ),
    .wr_be  (wr_be),
    .rd_en  (rd_load),
    .rd_idx (idx),
    .rd_dat (rd_dat)
  );

  // Main FSM with registered rd_valid, captured read address and sticky protocol flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rd_valid  <= 1'b0;
      proto_err <= 1'b0;
      addr_q    <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (viol) proto_err <= 1'b1;
      case (state)
        IDLE, WRITE: begin
          if (wr) begin
            state <= WRITE;
          end else if (rd) begin
            state <= RD_WAIT;
            cnt   <= lat_load(RD_LAT);
          end else begin
            state <= IDLE;
          end
        end
        RD_WAIT: begin
          if (wr) begin
            state <= WRITE;
          end else if (!rd) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state    <= RD_DRIVE;
            rd_valid <= 1'b1;
            addr_q   <= SRAM_ADDR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_DRIVE: begin
          if (wr) begin
            state <= WRITE;
          end else if (!rd) begin
            state <= IDLE;
          end else if (addr_chg) begin
            state <= RD_WAIT;
            cnt   <= lat_load(RD_LAT);
          end else begin
            rd_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_RESP_STATS_EN
  logic rd_entry;
  assign rd_entry = rd && ((state == IDLE) || ((state == RD_DRIVE) && addr_chg));

  // Saturating operation counters: read entries and lane-enabled write edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (rd_entry && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
      if ((wr_be != 2'b00) && wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed self-checking bench for sram_responder (RD_LAT=2, DEPTH_LOG2=16).
// Undriven DQ bits are pulled up, so a released lane reads as 8'hFF.
// Optional counters are checked when SRAM_RESP_STATS_EN is defined.
module tb_sram_responder;

  logic        clk;
  logic        rst;
  logic [17:0] addr;
  logic        ub, lb, we, ce, oe;
  logic        rd_valid, proto_err;
  logic [15:0] tb_dq;
  logic        tb_oe;
  wire  [15:0] dq;
`ifdef SRAM_RESP_STATS_EN
  logic [15:0] rd_cnt, wr_cnt;
`endif

  int checks = 0;
  int errs   = 0;

  assign dq = tb_oe ? tb_dq : 16'hzzzz;
  pullup pu_dq (dq);

  sram_responder #(
    .ADDR_W     (18),
    .DATA_W     (16),
    .DEPTH_LOG2 (16),
    .RD_LAT     (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .SRAM_DQ    (dq),
    .SRAM_ADDR  (addr),
    .SRAM_UB_EN (ub),
    .SRAM_LB_EN (lb),
    .SRAM_WE_EN (we),
    .SRAM_CE_EN (ce),
    .SRAM_OE_EN (oe),
    .rd_valid   (rd_valid),
    .proto_err  (proto_err)
`ifdef SRAM_RESP_STATS_EN
    ,
    .rd_cnt     (rd_cnt),
    .wr_cnt     (wr_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_idle();
    ce = 1'b1; we = 1'b1; oe = 1'b1; ub = 1'b0; lb = 1'b0; tb_oe = 1'b0;
  endtask

  // Two edges: the first enters WRITE, the second performs the write; then back to idle.
  task automatic do_write(input logic [17:0] a, input logic [15:0] d,
                          input logic u, input logic l);
    addr = a; tb_dq = d; tb_oe = 1'b1;
    ce = 1'b0; we = 1'b0; oe = 1'b1; ub = u; lb = l;
    tick();
    tick();
    set_idle();
    tick();
  endtask

  task automatic start_read(input logic [17:0] a);
    addr = a; tb_oe = 1'b0;
    ce = 1'b0; we = 1'b1; oe = 1'b0; ub = 1'b0; lb = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    addr = '0;
    tb_dq = '0;
    set_idle();
    #1;
    // Reset state
    chk("rst_rd_valid", {15'd0, rd_valid}, 16'h0000);
    chk("rst_proto_err", {15'd0, proto_err}, 16'h0000);
    chk("rst_dq_z", dq, 16'hFFFF);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Test 1: write BEEF, read with two clocks of latency
    do_write(18'h00010, 16'hBEEF, 1'b0, 1'b0);
    start_read(18'h00010);
    #1;
    chk("t1_pre_dq", dq, 16'hFFFF);
    tick();
    chk("t1_w0_dq", dq, 16'hFFFF);
    chk("t1_w0_rv", {15'd0, rd_valid}, 16'h0000);
    tick();
    chk("t1_w1_dq", dq, 16'hFFFF);
    chk("t1_w1_rv", {15'd0, rd_valid}, 16'h0000);
    tick();
    chk("t1_drv_dq", dq, 16'hBEEF);
    chk("t1_drv_rv", {15'd0, rd_valid}, 16'h0001);
    set_idle();
    #1;
    chk("t1_release_dq", dq, 16'hFFFF);
    tick();
    chk("t1_idle_rv", {15'd0, rd_valid}, 16'h0000);

    // Test 3: address change while driving restarts latency
    do_write(18'h00020, 16'h1234, 1'b0, 1'b0);
    start_read(18'h00010);
    tick(); tick(); tick();
    chk("t3_first_dq", dq, 16'hBEEF);
    addr = 18'h00020;
    tick();
    chk("t3_chg0_rv", {15'd0, rd_valid}, 16'h0000);
    chk("t3_chg0_dq", dq, 16'hFFFF);
    tick();
    chk("t3_chg1_rv", {15'd0, rd_valid}, 16'h0000);
    tick();
    chk("t3_new_rv", {15'd0, rd_valid}, 16'h0001);
    chk("t3_new_dq", dq, 16'h1234);
    set_idle();
    tick();

    // Test 2: upper-lane-only write, then lane-gated drive
    do_write(18'h00020, 16'hAB55, 1'b0, 1'b1);
    start_read(18'h00020);
    tick(); tick(); tick();
    chk("t2_merged_dq", dq, 16'hAB34);
    lb = 1'b1;
    #1;
    chk("t2_lb_off_dq", dq, 16'hABFF);
    set_idle();
    tick();

    // Test 4: WE and OE both low -> write wins, no drive, sticky error
    addr = 18'h00005; tb_dq = 16'h0F0F; tb_oe = 1'b1;
    ce = 1'b0; we = 1'b0; oe = 1'b0; ub = 1'b0; lb = 1'b0;
    #1;
    chk("t4_pre_perr", {15'd0, proto_err}, 16'h0000);
    tick();
    chk("t4_perr_set", {15'd0, proto_err}, 16'h0001);
    chk("t4_dq_nodrive", dq, 16'h0F0F);
    tick();
    set_idle();
    tick();
    start_read(18'h00005);
    tick(); tick(); tick();
    chk("t4_mem5", dq, 16'h0F0F);
    chk("t4_perr_sticky", {15'd0, proto_err}, 16'h0001);
    set_idle();
    tick();

    // Test 5: reset during drive releases at once, memory survives
    start_read(18'h00010);
    tick(); tick(); tick();
    chk("t5_pre_dq", dq, 16'hBEEF);
    rst = 1'b0;
    #1;
    chk("t5_rst_dq", dq, 16'hFFFF);
    chk("t5_rst_rv", {15'd0, rd_valid}, 16'h0000);
    chk("t5_rst_perr", {15'd0, proto_err}, 16'h0000);
    set_idle();
    tick();
    rst = 1'b1;
    tick();
`ifdef SRAM_RESP_STATS_EN
    chk("t5_rdcnt_rst", rd_cnt, 16'h0000);
    chk("t5_wrcnt_rst", wr_cnt, 16'h0000);
`endif
    start_read(18'h00010);
    tick(); tick(); tick();
    chk("t5_keep_dq", dq, 16'hBEEF);
    chk("t5_keep_rv", {15'd0, rd_valid}, 16'h0001);
    set_idle();
    tick();

    // Test 6: upper address bits alias; both-lanes-off write is a no-op
    do_write(18'h10003, 16'h7777, 1'b0, 1'b0);
    do_write(18'h00003, 16'h1111, 1'b1, 1'b1);
    start_read(18'h00003);
    tick(); tick(); tick();
    chk("t6_alias_dq", dq, 16'h7777);
    set_idle();
    tick();
`ifdef SRAM_RESP_STATS_EN
    chk("t6_rd_cnt", rd_cnt, 16'h0002);
    chk("t6_wr_cnt", wr_cnt, 16'h0001);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
